// File: rtl/alu_pkg.sv
// Shared types and flag bit positions for the ALU adder core.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/alu_carry_adder.sv
// Combinational WIDTH-bit adder with carry-in and carry-out.
module alu_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Extend by one bit so the carry-out falls out of the same addition.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_adder_core.sv
// Registered ADD/SUB/AND/OR slice producing a result and NZCV flags.
// Define ALU_ADDER_CORE_TRACE_EN for a simulation-only trace of internal nodes on each capture.
module alu_adder_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       alu_control,
    output logic [WIDTH-1:0] alu_result,
    output alu_flags_t       alu_flags,
    output logic             out_valid
);

    alu_op_e          op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] res;
    alu_flags_t       flags_next;

    assign op = alu_op_e'(alu_control);

    // SUB is A + ~B + 1, so the same control bit inverts B and supplies the carry-in.
    assign b_eff = alu_control[0] ? ~src_b : src_b;

    alu_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (src_a),
        .b    (b_eff),
        .cin  (alu_control[0]),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        res = sum;
        unique case (op)
            ALU_ADD, ALU_SUB: res = sum;
            ALU_AND:          res = src_a & src_b;
            ALU_OR:           res = src_a | src_b;
        endcase
    end

    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_N] = res[WIDTH-1];
        flags_next[FLAG_Z] = (res == '0);
        flags_next[FLAG_C] = ~alu_control[1] & cout;
        flags_next[FLAG_V] = ~alu_control[1]
                           & (src_a[WIDTH-1] ^ sum[WIDTH-1])
                           & ~(alu_control[0] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    end

    // NOTE: non-blocking assignments for all state; the async reset clears every register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result <= '0;
            alu_flags  <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_result <= res;
                alu_flags  <= flags_next;
            end
        end
    end

`ifdef ALU_ADDER_CORE_TRACE_EN
    always @(posedge clk) begin
        if (!reset && in_valid)
            $display("alu_adder_core: sum=%h cout=%h b_eff=%h res=%h", sum, cout, b_eff, res);
    end
`else
`endif

endmodule

// File: tb/tb_alu_adder_core.sv
// Directed, table-driven bench for alu_adder_core with hold and async-reset sequences.
module tb_alu_adder_core;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [1:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    alu_flags_t       alu_flags;
    logic             out_valid;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[13];

    alu_adder_core #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid    = v;
        alu_control = op;
        src_a       = a;
        src_b       = b;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 4'b0000};
        vecs[1]  = '{2'b01, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110};
        vecs[2]  = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000};
        vecs[3]  = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
        vecs[4]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
        vecs[5]  = '{2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000};
        vecs[6]  = '{2'b11, 32'hF000_0000, 32'h0000_0001, 32'hF000_0001, 4'b1000};
        vecs[7]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0110};
        vecs[8]  = '{2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 4'b0010};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};
        vecs[11] = '{2'b10, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 4'b0100};
        vecs[12] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};

        // Asynchronous reset takes effect with no clock edge.
        reset = 1'b0;
        drive(1'b0, 2'b00, '0, '0);
        #1 reset = 1'b1;
        #1;
        check("reset_result", alu_result, 32'h0);
        check("reset_flags", {28'h0, alu_flags}, 32'h0);
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back valid operations.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_result", i), alu_result, vecs[i].exp_res);
            check($sformatf("vec%0d_flags", i), {28'h0, alu_flags}, {28'h0, vecs[i].exp_flags});
            check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
        end

        // Hold: new operands without in_valid must not disturb the outputs.
        drive(1'b1, 2'b00, 32'h0000_0005, 32'h0000_0003);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b01, 32'h0000_0001, 32'h0000_0009);
        @(posedge clk);
        #1;
        check("hold_result", alu_result, 32'h0000_0008);
        check("hold_flags", {28'h0, alu_flags}, 32'h0);
        check("hold_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("hold2_result", alu_result, 32'h0000_0008);

        // Reset asserted between edges mid-stream.
        drive(1'b1, 2'b01, 32'h0000_0003, 32'h0000_0005);
        @(posedge clk);
        #1;
        check("pre_rst_result", alu_result, 32'hFFFF_FFFE);
        #2 reset = 1'b1;
        #1;
        check("midrst_result", alu_result, 32'h0);
        check("midrst_flags", {28'h0, alu_flags}, 32'h0);
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_result", alu_result, 32'h0);
        check("rst_held_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_000A, 32'h0000_0014);
        @(posedge clk);
        #1;
        check("post_rst_result", alu_result, 32'h0000_001E);
        check("post_rst_flags", {28'h0, alu_flags}, 32'h0);
        check("post_rst_valid", {31'h0, out_valid}, 32'h1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_drop_valid", {31'h0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
